pc_gen: RTL
===========

Name: pc_gen

Overview:
- Parametrised program-counter generator.
- Successor to the fixed 32-bit adder-plus-register PC: adds a valid/ready handshake to the fetch unit, prioritised redirect sources (trap, branch/jump), halt/resume control, target alignment checking, a redirect epoch bit and a fetch counter.
- Sits at the head of the NPC front-end: it drives instruction fetch and takes redirects from EXU and the trap/CSR logic.

Parameters:
- XLEN, 32, PC/target width in bits
- BOOT_VEC, 32'h80000000, first PC presented after reset; XLEN bits wide
- ILEN_BYTES, 4, sequential PC increment; power of two, 2 or 4
- CNT_W, 32, width of the fetch counter

Ports:
- clk  input  1  clock; rising edge active
- rst  input  1  asynchronous reset, active-low
- out_valid  output  1  out_pc is a fetch request
- out_ready  input  1  fetch unit accepts out_pc this cycle
- out_pc  output  XLEN  current PC
- out_epoch  output  1  toggles on every taken redirect
- redir_valid  input  1  branch/jump redirect from EXU
- redir_target  input  XLEN  branch/jump target
- trap_valid  input  1  trap/mret redirect
- trap_target  input  XLEN  trap/mret target (mtvec/mepc)
- halt_req  input  1  stop issuing fetches
- resume_req  input  1  leave HALT
- misalign_err  output  1  sticky; a redirect target was misaligned
- halted  output  1  state == HALT
- fetch_cnt  output  CNT_W  count of accepted handshakes

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=BOOT_VEC, state=BOOT, out_epoch=0, misalign_err=0, fetch_cnt=0.
  - Outputs: out_valid=0, halted=0.
- State BOOT:
  - Lasts exactly one clock after rst deasserts, then goes to RUN.
  - All request inputs are ignored.
- Transfer: a transfer occurs when out_valid=1 and out_ready=1 in the same cycle.
- State RUN: out_valid=1. Next-PC priority, highest first, evaluated at each rising edge:
  1. trap_valid: pc<=trap_target; epoch toggles.
  2. redir_valid: pc<=redir_target; epoch toggles.
  3. Transfer: pc<=pc+ILEN_BYTES, wrapping modulo 2^XLEN (e.g. all-ones minus 3 +4 -> 0).
  4. Otherwise pc holds. out_pc stays stable while out_valid=1 and out_ready=0, with no redirect.
- Redirect in the same cycle as a transfer: the transfer of the current pc still counts, and the next pc is the redirect target, not pc+ILEN_BYTES.
- Alignment:
  - A target is misaligned when target[log2(ILEN_BYTES)-1:0] != 0. The check applies only to the winning redirect source.
  - A misaligned winner leaves pc and epoch unchanged, sets misalign_err=1 and moves to HALT on that edge.
- Halt:
  - halt_req in RUN moves to HALT on the next edge. The pc update for that edge still follows the priority list above.
  - halt_req together with a misaligned redirect: HALT with misalign_err=1.
- State HALT:
  - out_valid=0, halted=1, pc holds.
  - trap_valid, redir_valid and halt_req are ignored.
  - resume_req moves to RUN on the next edge and clears misalign_err. out_valid=1 the following cycle, with the held pc.
- fetch_cnt:
  - Increments by 1 on each transfer.
  - Saturates at 2^CNT_W-1; no wrap.
- Reset asserted mid-operation: all state returns immediately to reset values. No pending redirect or halt survives reset.
- Latency: a redirect presented in cycle N appears on out_pc in cycle N+1.
- All outputs are driven directly from registers or from state decode; no combinational path from any input to any output.

Test Plan:
- Reset release, out_ready=1 constant -> cycle 1 out_valid=0 (BOOT); cycles 2..5 out_pc=0x80000000, 0x80000004, 0x80000008, 0x8000000C; fetch_cnt=4 after cycle 5.
- out_ready=0 for 3 cycles at pc 0x80000008 -> out_pc held at 0x80000008, fetch_cnt unchanged; ready=1 -> next 0x8000000C.
- redir_valid=1 with redir_target=0x80000100 and trap_valid=1 with trap_target=0x80000200, same cycle -> next out_pc=0x80000200, out_epoch toggles once; the next cycle with redir_valid alone (target 0x80000100) -> out_pc=0x80000100, epoch toggles back.
- redir_target=0x80000102 with ILEN_BYTES=4 -> misalign_err=1, halted=1, out_valid=0, pc held; resume_req -> misalign_err=0, out_valid=1 at the held pc.
- XLEN=16, BOOT_VEC=16'hFFFC, ready=1 -> out_pc 0xFFFC then 0x0000; CNT_W=2 -> fetch_cnt saturates at 3 after 4 transfers.
- rst asserted mid-stream with halt_req pending -> immediate out_valid=0, fetch_cnt=0, misalign_err=0, halted=0; after release, BOOT then RUN at 0x80000000.

Source files
------------

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator with fetch handshake, prioritised trap/branch
// redirects, halt/resume control, target alignment checking, epoch bit and fetch counter.
module pc_gen #(
    parameter int          XLEN       = 32,
    parameter logic [XLEN-1:0] BOOT_VEC = 32'h80000000,
    parameter int          ILEN_BYTES = 4,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic             out_epoch,
    input  logic             redir_valid,
    input  logic [XLEN-1:0]  redir_target,
    input  logic             trap_valid,
    input  logic [XLEN-1:0]  trap_target,
    input  logic             halt_req,
    input  logic             resume_req,
    output logic             misalign_err,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_cnt
);
    localparam int AW = $clog2(ILEN_BYTES);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d, tgt;
    logic              epoch_q, epoch_d, err_q, err_d, xfer, win, mis;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    assign out_valid    = state_q == RUN;
    assign halted       = state_q == HALT;
    assign out_pc       = pc_q;
    assign out_epoch    = epoch_q;
    assign misalign_err = err_q;
    assign fetch_cnt    = cnt_q;

    // Only the winning redirect source is alignment-checked.
    assign xfer = out_valid && out_ready;
    assign win  = trap_valid || redir_valid;
    assign tgt  = trap_valid ? trap_target : redir_target;
    assign mis  = win && (tgt[AW-1:0] != '0);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epoch_d = epoch_q;
        err_d   = err_q;
        cnt_d   = (xfer && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
        if (state_q == BOOT) begin
            state_d = RUN;
        end else if (state_q == RUN) begin
            if (mis) begin
                err_d   = 1'b1;
                state_d = HALT;
            end else if (win) begin
                pc_d    = tgt;
                epoch_d = ~epoch_q;
            end else if (xfer) begin
                pc_d = pc_q + XLEN'(ILEN_BYTES);
            end
            if (halt_req) state_d = HALT;
        end else if (resume_req) begin
            state_d = RUN;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BOOT;
            pc_q    <= BOOT_VEC;
            epoch_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epoch_q <= epoch_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
